// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: captures decoded control
// and operands, owns the load-use interlock, applies EX flush, counts bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_d,
  input  logic [3:0]       alu_ctrl_d,
  input  logic [2:0]       result_src_d,
  input  logic [1:0]       store_src_d,
  input  logic             mem_write_d,
  input  logic             alu_src_d,
  input  logic             reg_write_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic             op3_d,
  input  logic             op5_d,
  input  logic             is_load_d,
  input  logic [2:0]       funct3_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc4_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic             flush_e,
  input  logic             hold,
  output logic             stall_f,
  output logic             stall_d,
  output logic             valid_e,
  output logic [3:0]       alu_ctrl_e,
  output logic [2:0]       result_src_e,
  output logic [1:0]       store_src_e,
  output logic             mem_write_e,
  output logic             alu_src_e,
  output logic             reg_write_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             op3_e,
  output logic             op5_e,
  output logic             is_load_e,
  output logic [2:0]       funct3_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc4_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  imm_e,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [2:0] result_src;
    logic [1:0] store_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       op3;
    logic       op5;
    logic       is_load;
  } ctrl_t;

  typedef struct packed {
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
  } data_t;

  ctrl_t            ctrl_in, ctrl_q, ctrl_d;
  data_t            data_in, data_q, data_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  // An invalid decode slot carries no side effects: its control word is zeroed.
  always_comb begin
    ctrl_in = '0;
    if (valid_d) begin
      ctrl_in.alu_ctrl   = alu_ctrl_d;
      ctrl_in.result_src = result_src_d;
      ctrl_in.store_src  = store_src_d;
      ctrl_in.mem_write  = mem_write_d;
      ctrl_in.alu_src    = alu_src_d;
      ctrl_in.reg_write  = reg_write_d;
      ctrl_in.branch     = branch_d;
      ctrl_in.jump       = jump_d;
      ctrl_in.op3        = op3_d;
      ctrl_in.op5        = op5_d;
      ctrl_in.is_load    = is_load_d;
    end
  end

  always_comb begin
    data_in        = '0;
    data_in.funct3 = funct3_d;
    data_in.rs1    = rs1_d;
    data_in.rs2    = rs2_d;
    data_in.rd     = rd_d;
    data_in.pc     = pc_d;
    data_in.pc4    = pc4_d;
    data_in.rd1    = rd1_d;
    data_in.rd2    = rd2_d;
    data_in.imm    = imm_d;
  end

  // Conservative match on both source indices; x0 destinations never interlock.
  always_comb begin
    lu = vld_q & ctrl_q.is_load & (data_q.rd != 5'd0) & valid_d &
         ((data_q.rd == rs1_d) | (data_q.rd == rs2_d));
  end

  assign stall_f = lu & ~flush_e;
  assign stall_d = lu & ~flush_e;

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (hold) begin
      // everything frozen; a pending flush is re-asserted by EX later
    end else if (flush_e) begin
      ctrl_d = '0;
      data_d = '0;
      vld_d  = 1'b0;
    end else if (lu) begin
      ctrl_d = '0;
      data_d = '0;
      vld_d  = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ctrl_d = ctrl_in;
      data_d = data_in;
      vld_d  = valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_e      = vld_q;
  assign alu_ctrl_e   = ctrl_q.alu_ctrl;
  assign result_src_e = ctrl_q.result_src;
  assign store_src_e  = ctrl_q.store_src;
  assign mem_write_e  = ctrl_q.mem_write;
  assign alu_src_e    = ctrl_q.alu_src;
  assign reg_write_e  = ctrl_q.reg_write;
  assign branch_e     = ctrl_q.branch;
  assign jump_e       = ctrl_q.jump;
  assign op3_e        = ctrl_q.op3;
  assign op5_e        = ctrl_q.op5;
  assign is_load_e    = ctrl_q.is_load;
  assign funct3_e     = data_q.funct3;
  assign rs1_e        = data_q.rs1;
  assign rs2_e        = data_q.rs2;
  assign rd_e         = data_q.rd;
  assign pc_e         = data_q.pc;
  assign pc4_e        = data_q.pc4;
  assign rd1_e        = data_q.rd1;
  assign rd2_e        = data_q.rd2;
  assign imm_e        = data_q.imm;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage (CNT_W=4 build to reach saturation).
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_d, mem_write_d, alu_src_d, reg_write_d, branch_d, jump_d;
  logic op3_d, op5_d, is_load_d, flush_e, hold;
  logic [3:0] alu_ctrl_d;
  logic [2:0] result_src_d, funct3_d;
  logic [1:0] store_src_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] pc_d, pc4_d, rd1_d, rd2_d, imm_d;
  logic stall_f, stall_d, valid_e, mem_write_e, alu_src_e, reg_write_e;
  logic branch_e, jump_e, op3_e, op5_e, is_load_e;
  logic [3:0] alu_ctrl_e;
  logic [2:0] result_src_e, funct3_e;
  logic [1:0] store_src_e;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic [XLEN-1:0] pc_e, pc4_e, rd1_e, rd2_e, imm_e;
  logic [CNT_W-1:0] bubble_cnt;

  int n_vec = 0, n_mis = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .alu_ctrl_d(alu_ctrl_d),
    .result_src_d(result_src_d), .store_src_d(store_src_d),
    .mem_write_d(mem_write_d), .alu_src_d(alu_src_d), .reg_write_d(reg_write_d),
    .branch_d(branch_d), .jump_d(jump_d), .op3_d(op3_d), .op5_d(op5_d),
    .is_load_d(is_load_d), .funct3_d(funct3_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_d(rd_d), .pc_d(pc_d), .pc4_d(pc4_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_d(imm_d), .flush_e(flush_e), .hold(hold), .stall_f(stall_f),
    .stall_d(stall_d), .valid_e(valid_e), .alu_ctrl_e(alu_ctrl_e),
    .result_src_e(result_src_e), .store_src_e(store_src_e),
    .mem_write_e(mem_write_e), .alu_src_e(alu_src_e), .reg_write_e(reg_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .op3_e(op3_e), .op5_e(op5_e),
    .is_load_e(is_load_e), .funct3_e(funct3_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .pc_e(pc_e), .pc4_e(pc4_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_d();
    valid_d = 0; alu_ctrl_d = 0; result_src_d = 0; store_src_d = 0;
    mem_write_d = 0; alu_src_d = 0; reg_write_d = 0; branch_d = 0; jump_d = 0;
    op3_d = 0; op5_d = 0; is_load_d = 0; funct3_d = 0; rs1_d = 0; rs2_d = 0;
    rd_d = 0; pc_d = 0; pc4_d = 0; rd1_d = 0; rd2_d = 0; imm_d = 0;
  endtask

  task automatic load_d(input logic [4:0] rd, input logic [31:0] pc);
    clr_d();
    valid_d = 1; is_load_d = 1; reg_write_d = 1; alu_src_d = 1;
    result_src_d = 3'd1; funct3_d = 3'd2; rs1_d = 5'd2; rd_d = rd;
    pc_d = pc; pc4_d = pc + 4; imm_d = 32'h10;
  endtask

  task automatic alu_d(input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] pc);
    clr_d();
    valid_d = 1; reg_write_d = 1; rd_d = rd; rs1_d = rs1; rs2_d = rs2;
    pc_d = pc; pc4_d = pc + 4; rd1_d = 32'hA5A5_0001; rd2_d = 32'h5A5A_0002;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    clr_d(); flush_e = 0; hold = 0;
    #12;
    chk("rst_valid_e", valid_e, 0);
    chk("rst_cnt", bubble_cnt, 0);
    chk("rst_stall_f", stall_f, 0);
    rst_n = 1;
    step();

    // lw x5 ; add x6,x5,x1
    load_d(5, 32'h100);
    step();
    chk("lw_valid_e", valid_e, 1);
    chk("lw_is_load_e", is_load_e, 1);
    chk("lw_rd_e", rd_e, 5);
    alu_d(6, 5, 1, 32'h104); #1;
    chk("lu_stall_f", stall_f, 1);
    chk("lu_stall_d", stall_d, 1);
    step();
    chk("bub_valid_e", valid_e, 0);
    chk("bub_reg_write_e", reg_write_e, 0);
    chk("bub_cnt", bubble_cnt, 1);
    chk("bub_stall_f", stall_f, 0);
    step();
    chk("add_valid_e", valid_e, 1);
    chk("add_rd_e", rd_e, 6);
    chk("add_pc_e", pc_e, 32'h104);
    chk("add_rd1_e", rd1_e, 32'hA5A5_0001);

    // lw x0 ; add x6,x0,x1 : no interlock
    load_d(0, 32'h200);
    step();
    alu_d(6, 0, 1, 32'h204); #1;
    chk("x0_stall_f", stall_f, 0);
    step();
    chk("x0_valid_e", valid_e, 1);
    chk("x0_cnt", bubble_cnt, 1);

    // lw x5 ; add x6,x7,x8 : independent
    load_d(5, 32'h300);
    step();
    alu_d(6, 7, 8, 32'h304); #1;
    chk("indep_stall_d", stall_d, 0);
    step();
    chk("indep_valid_e", valid_e, 1);
    chk("indep_pc_e", pc_e, 32'h304);

    // load-use together with flush: flush wins
    load_d(5, 32'h400);
    step();
    alu_d(6, 5, 1, 32'h404); flush_e = 1; #1;
    chk("lufl_stall_f", stall_f, 0);
    step();
    chk("lufl_valid_e", valid_e, 0);
    chk("lufl_cnt", bubble_cnt, 1);
    flush_e = 0;

    // hold with flush: frozen for 3 cycles, then flush applies
    load_d(5, 32'h500);
    step();
    alu_d(9, 1, 2, 32'h504); hold = 1; flush_e = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid_e", valid_e, 1);
      chk("hold_pc_e", pc_e, 32'h500);
    end
    hold = 0;
    step();
    chk("unhold_valid_e", valid_e, 0);
    chk("unhold_rd_e", rd_e, 0);
    flush_e = 0;

    // invalid decode slot: control zeroed, data copied
    alu_d(7, 3, 4, 32'h600); valid_d = 0; mem_write_d = 1;
    step();
    chk("inv_valid_e", valid_e, 0);
    chk("inv_reg_write_e", reg_write_e, 0);
    chk("inv_mem_write_e", mem_write_e, 0);
    chk("inv_pc_e", pc_e, 32'h600);

    // async reset mid-cycle
    load_d(5, 32'h700);
    step();
    chk("pre_rst_reg_write_e", reg_write_e, 1);
    #2 rst_n = 0; #1;
    chk("mid_rst_valid_e", valid_e, 0);
    chk("mid_rst_reg_write_e", reg_write_e, 0);
    chk("mid_rst_cnt", bubble_cnt, 0);
    rst_n = 1;
    step();

    // 18 load-use events on a 4-bit counter: saturates at F
    for (int i = 0; i < 18; i++) begin
      load_d(5, 32'h800);
      step();
      alu_d(6, 5, 1, 32'h804);
      step();
      if (i == 13) chk("sat_cnt14", bubble_cnt, 14);
      if (i == 14) chk("sat_cnt15", bubble_cnt, 15);
    end
    chk("sat_cnt_final", bubble_cnt, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
